// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command-frame controller: FSM states, error codes, default sync marker.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    HUNT,
    OPCODE,
    LEN,
    PAYLOAD,
    CHECK,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    ERR_CHK     = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_t;

  // States in which a partially received frame can go stale.
  function automatic logic in_frame(state_t s);
    return (s == OPCODE) || (s == LEN) || (s == PAYLOAD) || (s == CHECK);
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: down-counter reloaded on clear, expires on the TIMEOUT_CLKS-th idle clock.
module uart_idle_timer #(
  parameter int TIMEOUT_CLKS = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = en && !clear && (cnt == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind the UART receiver: SYNC/OPCODE/LEN/PAYLOAD/CHK, payload buffer,
// valid/ready command hand-off, error strobe and counters.
//
// state   | meaning
// HUNT    | idle, waiting for SYNC_BYTE
// OPCODE  | next byte is the opcode
// LEN     | next byte is the payload length
// PAYLOAD | storing payload bytes into the buffer
// CHECK   | next byte is the XOR checksum
// HOLD    | verified command presented until cmd_ready
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         MAX_PAYLOAD  = 16,
  parameter int         TIMEOUT_CLKS = 100_000,
  localparam int        LEN_W        = $clog2(MAX_PAYLOAD + 1),
  localparam int        ADDR_W       = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_opcode,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state;
  err_code_t         err_code_q;
  logic [7:0]        chk;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        payload [DEPTH];

  logic      tmr_expire;
  logic      err_det;
  err_code_t err_sel;

  uart_idle_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (rx_valid || !in_frame(state)),
    .en    (in_frame(state)),
    .expire(tmr_expire)
  );

  // Byte arrival takes precedence over a timeout expiring on the same clock.
  always_comb begin
    err_det = 1'b0;
    err_sel = ERR_CHK;
    if (tmr_expire) begin
      err_det = 1'b1;
      err_sel = ERR_TIMEOUT;
    end else if (rx_valid) begin
      case (state)
        LEN: begin
          if (int'(rx_data) > MAX_PAYLOAD) begin
            err_det = 1'b1;
            err_sel = ERR_LEN;
          end
        end
        CHECK: begin
          if (rx_data != chk) begin
            err_det = 1'b1;
            err_sel = ERR_CHK;
          end
        end
        HOLD: begin
          if (!cmd_ready) begin
            err_det = 1'b1;
            err_sel = ERR_OVERRUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      cmd_valid  <= 1'b0;
      cmd_opcode <= 8'd0;
      cmd_len    <= '0;
      err_pulse  <= 1'b0;
      err_code_q <= ERR_CHK;
      frame_cnt  <= 16'd0;
      err_cnt    <= 8'd0;
      chk        <= 8'd0;
      idx        <= '0;
    end else begin
      err_pulse <= err_det;
      if (err_det) begin
        err_code_q <= err_sel;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end

      if (tmr_expire) begin
        state <= HUNT;
      end else if ((state == HOLD) && cmd_ready) begin
        // Retiring the command frees the parser, so a same-cycle byte is hunted normally.
        cmd_valid <= 1'b0;
        state     <= (rx_valid && (rx_data == SYNC_BYTE)) ? OPCODE : HUNT;
      end else if (rx_valid) begin
        case (state)
          HUNT: begin
            if (rx_data == SYNC_BYTE) state <= OPCODE;
          end
          OPCODE: begin
            cmd_opcode <= rx_data;
            chk        <= rx_data;
            state      <= LEN;
          end
          LEN: begin
            if (int'(rx_data) > MAX_PAYLOAD) begin
              state <= HUNT;
            end else begin
              cmd_len <= LEN_W'(rx_data);
              chk     <= chk ^ rx_data;
              idx     <= '0;
              state   <= (rx_data == 8'd0) ? CHECK : PAYLOAD;
            end
          end
          PAYLOAD: begin
            chk <= chk ^ rx_data;
            idx <= idx + ADDR_W'(1);
            if (LEN_W'(idx) == (cmd_len - LEN_W'(1))) state <= CHECK;
          end
          CHECK: begin
            if (rx_data == chk) begin
              cmd_valid <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
              state     <= HOLD;
            end else begin
              state <= HUNT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Buffer is only written while parsing, so the held command's payload cannot change under the reader.
  always_ff @(posedge clk) begin
    if (rx_valid && (state == PAYLOAD) && !tmr_expire) payload[idx] <= rx_data;
  end

  assign rd_data  = payload[rd_addr];
  assign busy     = (state != HUNT);
  assign err_code = err_code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frame table, corner sequences and a random
// byte stream compared every clock against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int         MAXP   = 16;
  localparam int         T      = 20;
  localparam int         LEN_W  = 5;
  localparam int         ADDR_W = 4;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_opcode;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              busy;
  logic              err_pulse;
  logic [1:0]        err_code;
  logic [15:0]       frame_cnt;
  logic [7:0]        err_cnt;

  uart_cmd_ctrl #(
    .SYNC_BYTE   (SYNC),
    .MAX_PAYLOAD (MAXP),
    .TIMEOUT_CLKS(T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_len   (cmd_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame in progress is simply the list of bytes collected since SYNC.
  bit         m_held;
  logic [7:0] m_op;
  int         m_len;
  logic [7:0] m_pay [MAXP];
  logic [7:0] m_q [$];
  int         m_idle;
  logic [15:0] m_fc;
  logic [7:0] m_ec;
  logic [1:0] m_code;
  bit         m_pulse;

  function automatic void m_reset();
    m_held = 0; m_op = 0; m_len = 0; m_q.delete(); m_idle = 0;
    m_fc = 0; m_ec = 0; m_code = 0; m_pulse = 0;
  endfunction

  function automatic bit m_busy();
    return m_held || (m_q.size() != 0);
  endfunction

  function automatic void m_err(input logic [1:0] c);
    m_pulse = 1;
    m_code  = c;
    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
  endfunction

  function automatic void m_step(input bit v, input logic [7:0] d, input bit r);
    logic [7:0] x;
    m_pulse = 0;
    if (m_held) begin
      if (r) begin
        m_held = 0;
        if (v && d == SYNC) begin m_q.push_back(d); m_idle = 0; end
      end else if (v) begin
        m_err(2'd3);
      end
    end else if (m_q.size() != 0) begin
      if (!v) begin
        m_idle++;
        if (m_idle == T) begin m_err(2'd2); m_q.delete(); end
      end else begin
        m_idle = 0;
        m_q.push_back(d);
        if (m_q.size() == 3 && int'(m_q[2]) > MAXP) begin
          m_err(2'd1);
          m_q.delete();
        end else if (m_q.size() >= 4 && m_q.size() == int'(m_q[2]) + 4) begin
          x = 8'd0;
          for (int i = 1; i < m_q.size() - 1; i++) x = x ^ m_q[i];
          if (x == m_q[m_q.size()-1]) begin
            m_held = 1;
            m_op   = m_q[1];
            m_len  = int'(m_q[2]);
            for (int i = 0; i < m_len; i++) m_pay[i] = m_q[3+i];
            m_fc = m_fc + 16'd1;
          end else begin
            m_err(2'd0);
          end
          m_q.delete();
        end
      end
    end else if (v && d == SYNC) begin
      m_q.push_back(d);
      m_idle = 0;
    end
  endfunction

  // One clock: drive, let the DUT sample, step the model, compare after the edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r);
    rx_valid = v; rx_data = d; cmd_ready = r;
    @(posedge clk);
    m_step(v, d, r);
    if (m_held && m_len > 0) rd_addr = ADDR_W'($urandom_range(0, m_len - 1));
    #1;
    check("cycle_status", {cmd_valid, busy, err_pulse, err_code, frame_cnt, err_cnt},
          {m_held, m_busy(), m_pulse, m_code, m_fc, m_ec});
    if (m_held) begin
      check("cycle_hold_cmd", {cmd_opcode, 3'b000, cmd_len}, {m_op, 8'(m_len)});
      if (m_len > 0) check("cycle_rd_data", rd_data, m_pay[rd_addr]);
    end
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [159:0] b;
    int           n;
    bit           exp_cmd;
    logic [7:0]   op;
    int           len;
    int           poff;
    logic [1:0]   code;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [7:0] vbyte(input vec_t v, input int i);
    return v.b[8*(v.n-1-i) +: 8];
  endfunction

  logic [7:0] txq [$];
  int         gap;

  task automatic gen_frame();
    int         kind;
    int         len;
    logic [7:0] op;
    logic [7:0] x;
    logic [7:0] pb;
    kind = $urandom_range(0, 9);
    op   = 8'($urandom);
    len  = $urandom_range(0, MAXP);
    if (kind <= 5 || kind == 9) begin
      if (kind == 9) gap = $urandom_range(0, T + 5);
      txq.push_back(SYNC); txq.push_back(op); txq.push_back(8'(len));
      x = op ^ 8'(len);
      for (int i = 0; i < len; i++) begin
        pb = 8'($urandom);
        txq.push_back(pb);
        x = x ^ pb;
      end
      if (kind == 5) x = x ^ (8'd1 << $urandom_range(0, 7));
      txq.push_back(x);
    end else if (kind == 6) begin
      txq.push_back(SYNC); txq.push_back(op); txq.push_back(8'($urandom_range(MAXP + 1, 255)));
    end else if (kind == 7) begin
      txq.push_back(8'($urandom));
    end else begin
      txq.push_back(SYNC); txq.push_back(op); txq.push_back(8'(len));
      gap = T + 3;
    end
  endtask

  int  k;
  bit  r;

  initial begin
    vecs[0] = '{b:160'hA5_01_02_10_20_33, n:6, exp_cmd:1'b1, op:8'h01, len:2, poff:3, code:2'd0};
    vecs[1] = '{b:160'hA5_07_00_07, n:4, exp_cmd:1'b1, op:8'h07, len:0, poff:3, code:2'd0};
    vecs[2] = '{b:160'hA5_07_00_06, n:4, exp_cmd:1'b0, op:8'h00, len:0, poff:0, code:2'd0};
    vecs[3] = '{b:160'hA5_01_11, n:3, exp_cmd:1'b0, op:8'h00, len:0, poff:0, code:2'd1};
    vecs[4] = '{b:160'hA5_3C_10_00010203_04050607_08090A0B_0C0D0E0F_2C, n:20, exp_cmd:1'b1,
                op:8'h3C, len:16, poff:3, code:2'd0};
    vecs[5] = '{b:160'h11_22_A5_02_01_FF_FC, n:7, exp_cmd:1'b1, op:8'h02, len:1, poff:5, code:2'd0};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; cmd_ready = 1'b0; rd_addr = '0; gap = 0;
    m_reset();
    #120;
    check("reset_outputs", {cmd_valid, busy, err_pulse, err_code, frame_cnt, err_cnt, cmd_opcode, cmd_len}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Directed frame table.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n; i++) cycle(1'b1, vbyte(vecs[v], i), 1'b0);
      if (vecs[v].exp_cmd) begin
        check("vec_valid", cmd_valid, 1);
        check("vec_opcode", cmd_opcode, vecs[v].op);
        check("vec_len", cmd_len, vecs[v].len);
        for (int i = 0; i < vecs[v].len; i++) begin
          rd_addr = ADDR_W'(i);
          #1;
          check("vec_rd_data", rd_data, vbyte(vecs[v], vecs[v].poff + i));
        end
        cycle(1'b0, 8'd0, 1'b1);
        check("vec_retire", cmd_valid, 0);
      end else begin
        check("vec_err_pulse", err_pulse, 1);
        check("vec_err_code", err_code, vecs[v].code);
        check("vec_busy", busy, 0);
      end
    end

    // Length error: following bytes are ignored until the next SYNC.
    cycle(1'b1, 8'h07, 1'b0); cycle(1'b1, 8'h00, 1'b0); cycle(1'b1, 8'h07, 1'b0);
    check("len_err_ignored", {busy, cmd_valid}, 2'b00);

    // Inter-byte timeout.
    cycle(1'b1, SYNC, 1'b0);
    cycle(1'b1, 8'h01, 1'b0);
    k = 0;
    for (int i = 1; i <= 3 * T; i++) begin
      cycle(1'b0, 8'd0, 1'b0);
      if (err_pulse) begin k = i; break; end
    end
    check("timeout_idle_cycles", k, T);
    check("timeout_code", err_code, 2);
    check("timeout_busy", busy, 0);
    for (int i = 0; i < vecs[1].n; i++) cycle(1'b1, vbyte(vecs[1], i), 1'b0);
    check("after_timeout_valid", {cmd_valid, cmd_opcode}, {1'b1, 8'h07});
    cycle(1'b0, 8'd0, 1'b1);

    // Overrun while holding, then retire with a same-cycle SYNC.
    for (int i = 0; i < vecs[0].n; i++) cycle(1'b1, vbyte(vecs[0], i), 1'b0);
    cycle(1'b1, 8'h55, 1'b0);
    check("overrun_pulse", err_pulse, 1);
    check("overrun_code", err_code, 3);
    check("overrun_held", {cmd_valid, cmd_opcode, 3'b000, cmd_len}, {1'b1, 8'h01, 8'h02});
    rd_addr = 4'd0; #1; check("overrun_rd0", rd_data, 8'h10);
    rd_addr = 4'd1; #1; check("overrun_rd1", rd_data, 8'h20);
    cycle(1'b1, SYNC, 1'b1);
    check("retire_sync", {cmd_valid, busy}, 2'b01);
    cycle(1'b1, 8'h07, 1'b0); cycle(1'b1, 8'h00, 1'b0); cycle(1'b1, 8'h07, 1'b0);
    check("retire_sync_frame", {cmd_valid, cmd_opcode}, {1'b1, 8'h07});
    cycle(1'b0, 8'd0, 1'b1);

    // Random byte stream against the model.
    for (int c = 0; c < 4000; c++) begin
      if (txq.size() == 0 && gap == 0) gen_frame();
      r = ($urandom_range(0, 3) != 0);
      if (gap > 0) begin
        gap--;
        cycle(1'b0, 8'd0, r);
      end else if (txq.size() != 0 && $urandom_range(0, 3) != 0) begin
        cycle(1'b1, txq.pop_front(), r);
      end else begin
        cycle(1'b0, 8'd0, r);
      end
    end
    for (int i = 0; i < T + 5; i++) cycle(1'b0, 8'd0, 1'b1);

    // Asynchronous reset in the middle of a payload.
    cycle(1'b1, SYNC, 1'b1); cycle(1'b1, 8'h01, 1'b1); cycle(1'b1, 8'h02, 1'b1); cycle(1'b1, 8'h10, 1'b1);
    #20;
    rst_n = 1'b0;
    #1;
    check("midframe_reset", {cmd_valid, busy, err_pulse, err_code, frame_cnt, err_cnt, cmd_opcode, cmd_len}, 64'd0);
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < vecs[0].n; i++) cycle(1'b1, vbyte(vecs[0], i), 1'b1);
    check("post_reset_frame", {cmd_valid, frame_cnt}, {1'b1, 16'd1});
    cycle(1'b0, 8'd0, 1'b1);

    // Error counter saturation.
    for (int f = 0; f < 256; f++)
      for (int i = 0; i < vecs[2].n; i++) cycle(1'b1, vbyte(vecs[2], i), 1'b1);
    check("err_cnt_saturated", err_cnt, 8'hFF);
    for (int i = 0; i < vecs[2].n; i++) cycle(1'b1, vbyte(vecs[2], i), 1'b1);
    check("sat_err_pulse", err_pulse, 1);
    check("sat_err_cnt", err_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
